// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetched beats into a 2-entry skid buffer
// feeding execute, with flush and a wrapping handed-down beat count.
module decode_stage #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic             out_funct7b5,
   output logic [31:0]      out_imm,
   output logic [3:0]       out_op_class,
   output logic             out_illegal,
   output logic [CNT_W-1:0] out_count
);

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic [31:0]     imm;
      logic [3:0]      op_class;
      logic            illegal;
   } dec_t;

   dec_t             dec;
   dec_t             ent_q [2];
   dec_t             ent_d [2];
   logic [1:0]       occ_q, occ_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] imm;
   logic [3:0]  cls;
   logic        has_rd;
   logic        bad;

   assign opcode = in_instr[6:0];
   assign f3     = in_instr[14:12];
   assign f7     = in_instr[31:25];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      cls    = 4'd15;
      imm    = '0;
      has_rd = 1'b0;
      bad    = 1'b0;
      case (opcode)
         7'b0110111: begin cls = 4'd0; imm = imm_u; has_rd = 1'b1; end
         7'b0010111: begin cls = 4'd1; imm = imm_u; has_rd = 1'b1; end
         7'b1101111: begin cls = 4'd2; imm = imm_j; has_rd = 1'b1; end
         7'b1100111: begin
            cls = 4'd3; imm = imm_i; has_rd = 1'b1;
            bad = (f3 != 3'b000);
         end
         7'b1100011: begin
            cls = 4'd4; imm = imm_b;
            bad = (f3[2:1] == 2'b01);
         end
         7'b0000011: begin
            cls = 4'd5; imm = imm_i; has_rd = 1'b1;
            bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         7'b0100011: begin
            cls = 4'd6; imm = imm_s;
            bad = (f3 >= 3'b011);
         end
         7'b0010011: begin
            cls = 4'd7; imm = imm_i; has_rd = 1'b1;
            if (f3 == 3'b001)
               bad = (f7 != 7'b0000000);
            else if (f3 == 3'b101)
               bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
         end
         7'b0110011: begin
            cls = 4'd8; has_rd = 1'b1;
            bad = !((f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) &&
                     ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         7'b0001111: cls = 4'd9;
         7'b1110011: begin cls = 4'd10; has_rd = 1'b1; end
         default:    bad = 1'b1;
      endcase
      // illegal beats carry no destination or immediate
      if (bad) begin
         cls    = 4'd15;
         imm    = '0;
         has_rd = 1'b0;
      end
   end

   always_comb begin
      dec.pc       = in_pc;
      dec.rd       = has_rd ? in_instr[11:7] : 5'd0;
      dec.rs1      = in_instr[19:15];
      dec.rs2      = in_instr[24:20];
      dec.funct3   = f3;
      dec.funct7b5 = in_instr[30];
      dec.imm      = imm;
      dec.op_class = cls;
      dec.illegal  = bad;
   end

   logic       push, pop;
   logic [1:0] tail;

   assign push = in_valid & in_ready_q & ~flush;
   assign pop  = (occ_q != 2'd0) & out_ready;
   assign tail = occ_q - {1'b0, pop};

   always_comb begin
      ent_d   = ent_q;
      occ_d   = occ_q;
      count_d = count_q + {{(CNT_W-1){1'b0}}, pop};
      if (pop)
         ent_d[0] = ent_q[1];
      if (flush) begin
         occ_d = 2'd0;
      end else begin
         if (push) begin
            if (tail == 2'd0)
               ent_d[0] = dec;
            else
               ent_d[1] = dec;
         end
         occ_d = occ_q + {1'b0, push} - {1'b0, pop};
      end
      in_ready_d = (occ_d != 2'd2);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_q      <= '{default: '0};
         occ_q      <= 2'd0;
         in_ready_q <= 1'b0;
         count_q    <= '0;
      end else begin
         ent_q      <= ent_d;
         occ_q      <= occ_d;
         in_ready_q <= in_ready_d;
         count_q    <= count_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = (occ_q != 2'd0);
   assign out_pc       = ent_q[0].pc;
   assign out_rd       = ent_q[0].rd;
   assign out_rs1      = ent_q[0].rs1;
   assign out_rs2      = ent_q[0].rs2;
   assign out_funct3   = ent_q[0].funct3;
   assign out_funct7b5 = ent_q[0].funct7b5;
   assign out_imm      = ent_q[0].imm;
   assign out_op_class = ent_q[0].op_class;
   assign out_illegal  = ent_q[0].illegal;
   assign out_count    = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected records queued on push,
// compared in order on pop.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [2:0]  out_funct3;
   logic        out_funct7b5;
   logic [31:0] out_imm;
   logic [3:0]  out_op_class;
   logic        out_illegal;
   logic [15:0] out_count;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   exp_t exp_cur;
   exp_t sb [$];
   int   checks   = 0;
   int   failures = 0;

   decode_stage #(.PC_W(32), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_rd       (out_rd),
      .out_rs1      (out_rs1),
      .out_rs2      (out_rs2),
      .out_funct3   (out_funct3),
      .out_funct7b5 (out_funct7b5),
      .out_imm      (out_imm),
      .out_op_class (out_op_class),
      .out_illegal  (out_illegal),
      .out_count    (out_count)
   );

   always #5 clk = ~clk;

   // Inputs only change at posedge+1, so negedge values are the edge values.
   always @(negedge clk) begin
      exp_t act, e;
      if (reset) begin
         if (out_valid && out_ready) begin
            act = '{out_pc, out_op_class, out_rd, out_imm, out_illegal};
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL pop_unexpected got=%h required=none", act);
            end else begin
               e = sb.pop_front();
               if (act !== e) begin
                  failures++;
                  $display("FAIL pop_record got=%h required=%h", act, e);
               end
            end
         end
         if (flush)
            sb.delete();
         if (in_valid && in_ready && !flush)
            sb.push_back(exp_cur);
      end
   end

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [3:0] cls, input logic [4:0] rd,
                        input logic [31:0] imm, input logic ill);
      in_instr = instr;
      in_pc    = pc;
      in_valid = 1'b1;
      exp_cur  = '{pc, cls, rd, imm, ill};
   endtask

   task automatic wait_accept(input string name);
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_accept got=timeout required=accepted", name);
      end
   endtask

   task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [3:0] cls, input logic [4:0] rd,
                       input logic [31:0] imm, input logic ill);
      drive(instr, pc, cls, rd, imm, ill);
      wait_accept("send");
   endtask

   task automatic drain(input string name);
      bit done = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && !out_valid) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL %s_drain got=pending=%0d required=0", name, sb.size());
      end
   endtask

   task automatic test_reset;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      exp_cur   = '0;
      #12;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_out_valid got=%b required=0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_in_ready got=%b required=0", in_ready);
      end
      checks++;
      if (out_count !== 16'd0) begin
         failures++;
         $display("FAIL rst_count got=%0d required=0", out_count);
      end
      checks++;
      if (out_imm !== 32'd0 || out_pc !== 32'd0 || out_op_class !== 4'd0) begin
         failures++;
         $display("FAIL rst_data got=%h/%h/%h required=0",
                  out_imm, out_pc, out_op_class);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_in_ready_rise got=%b required=1", in_ready);
      end
   endtask

   task automatic test_single;
      out_ready = 1'b0;
      send(32'h00500093, 32'h0, 4'd7, 5'd1, 32'h5, 1'b0);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL single_latency got=%b required=1", out_valid);
      end
      checks++;
      if (out_op_class !== 4'd7 || out_rs1 !== 5'd0 || out_rd !== 5'd1) begin
         failures++;
         $display("FAIL single_fields got=%0d/%0d/%0d required=7/0/1",
                  out_op_class, out_rs1, out_rd);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_count !== 16'd1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_pop got=%0d/%b required=1/0",
                  out_count, out_valid);
      end
   endtask

   task automatic test_imm_formats;
      out_ready = 1'b1;
      send(32'hFE000EE3, 32'h10, 4'd4, 5'd0, 32'hFFFFFFFC, 1'b0);
      send(32'h123450B7, 32'h14, 4'd0, 5'd1, 32'h12345000, 1'b0);
      send(32'hFF9FF06F, 32'h18, 4'd2, 5'd0, 32'hFFFFFFF8, 1'b0);
      send(32'hFFC12183, 32'h1C, 4'd5, 5'd3, 32'hFFFFFFFC, 1'b0);
      send(32'hFE112E23, 32'h20, 4'd6, 5'd0, 32'hFFFFFFFC, 1'b0);
      drain("imm");
      checks++;
      if (out_count !== 16'd6) begin
         failures++;
         $display("FAIL imm_count got=%0d required=6", out_count);
      end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      drive(32'h00100113, 32'h100, 4'd7, 5'd2, 32'h1, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_ready_occ1 got=%b required=1", in_ready);
      end
      drive(32'h00200193, 32'h104, 4'd7, 5'd3, 32'h2, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_ready_full got=%b required=0", in_ready);
      end
      drive(32'h00300213, 32'h108, 4'd7, 5'd4, 32'h3, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h100) begin
         failures++;
         $display("FAIL bp_hold got=%b/%b/%h required=0/1/00000100",
                  in_ready, out_valid, out_pc);
      end
      out_ready = 1'b1;
      wait_accept("bp");
      drain("bp");
      checks++;
      if (out_count !== 16'd9) begin
         failures++;
         $display("FAIL bp_count got=%0d required=9", out_count);
      end
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      send(32'h00500293, 32'h200, 4'd7, 5'd5, 32'h5, 1'b0);
      send(32'h00600313, 32'h204, 4'd7, 5'd6, 32'h6, 1'b0);
      drive(32'h00700393, 32'h208, 4'd7, 5'd7, 32'h7, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_state got=%b/%b required=0/1",
                  out_valid, in_ready);
      end
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (out_count !== 16'd9 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_dropped got=%0d/%b required=9/0",
                  out_count, out_valid);
      end
      out_ready = 1'b0;
      send(32'h00800413, 32'h20C, 4'd7, 5'd8, 32'h8, 1'b0);
      out_ready = 1'b1;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if (out_count !== 16'd10 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_pop_count got=%0d/%b required=10/0",
                  out_count, out_valid);
      end
   endtask

   task automatic test_illegal;
      out_ready = 1'b0;
      send(32'h00000000, 32'h300, 4'd15, 5'd0, 32'h0, 1'b1);
      checks++;
      if (out_illegal !== 1'b1 || out_op_class !== 4'd15) begin
         failures++;
         $display("FAIL illegal_head got=%b/%0d required=1/15",
                  out_illegal, out_op_class);
      end
      out_ready = 1'b1;
      send(32'h4000F033, 32'h304, 4'd15, 5'd0, 32'h0, 1'b1);
      send(32'h00001067, 32'h308, 4'd15, 5'd0, 32'h0, 1'b1);
      send(32'h4000D093, 32'h30C, 4'd7, 5'd1, 32'h400, 1'b0);
      send(32'h4000A033, 32'h310, 4'd15, 5'd0, 32'h0, 1'b1);
      drain("illegal");
      checks++;
      if (out_count !== 16'd15) begin
         failures++;
         $display("FAIL illegal_count got=%0d required=15", out_count);
      end
   endtask

   task automatic test_async_reset;
      out_ready = 1'b0;
      send(32'h00900493, 32'h400, 4'd7, 5'd9, 32'h9, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      sb.delete();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_count !== 16'd0) begin
         failures++;
         $display("FAIL async_reset got=%b/%b/%0d required=0/0/0",
                  out_valid, in_ready, out_count);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_recover got=%b/%b required=1/0",
                  in_ready, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_imm_formats();
      test_backpressure();
      test_flush();
      test_illegal();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage directly downstream of the fetch unit.
- Accepts fetched instruction/PC beats over a valid/ready handshake and decodes register indices, immediate, operation class and illegal flag.
- Holds decoded results in a 2-entry skid buffer feeding execute; supports pipeline flush on redirect.
- Keeps a wrapping count of instructions handed downstream.

Parameters:
- PC_W, 32, width of the program counter carried with each instruction
- CNT_W, 16, width of the retired-to-execute instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  stage can accept a beat; registered, no combinational path from out_ready
- in_instr  in  32  fetched instruction word
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  synchronous discard of all held and incoming beats
- out_valid  out  1  decoded beat available at head of buffer
- out_ready  in  1  execute accepts head beat
- out_pc  out  PC_W  PC of head beat
- out_rd  out  5  instr[11:7] for LUI/AUIPC/JAL/JALR/LOAD/OP_IMM/OP/SYSTEM; 0 otherwise
- out_rs1  out  5  instr[19:15], raw
- out_rs2  out  5  instr[24:20], raw
- out_funct3  out  3  instr[14:12]
- out_funct7b5  out  1  instr[30]
- out_imm  out  32  sign-extended immediate per format; 0 for OP/MISC_MEM/SYSTEM
- out_op_class  out  4  LUI=0 AUIPC=1 JAL=2 JALR=3 BRANCH=4 LOAD=5 STORE=6 OP_IMM=7 OP=8 MISC_MEM=9 SYSTEM=10 ILLEGAL=15
- out_illegal  out  1  head beat is illegal; out_op_class=15 iff set
- out_count  out  CNT_W  handshaken output beats since reset

Behaviour:
- Reset (reset==0, async):
  - occupancy=0, out_valid=0, in_ready=0.
  - All data outputs 0; out_count=0.
  - in_ready rises to 1 on the first clk edge after reset deasserts.
- Push: in_valid & in_ready & ~flush at a rising edge.
  - Decode is combinational on the input; the decoded record is written to the tail entry.
- Pop: out_valid & out_ready at a rising edge; removes head, increments out_count (mod 2^CNT_W).
- Latency: beat pushed at edge N is visible with out_valid=1 after edge N when the buffer was empty (1 cycle); otherwise in order behind older entries. Strict FIFO order.
- Occupancy 0..2:
  - out_valid = (occupancy!=0).
  - in_ready registered = next occupancy < 2.
  - Push and pop in the same edge leave occupancy unchanged.
  - in_ready is 0 at occupancy 2, so no push occurs when full.
- Flush at an edge:
  - occupancy->0, out_valid->0.
  - The beat offered that cycle is dropped.
  - A pop handshaked in the same cycle still counts in out_count.
  - in_ready=1 next cycle.
- Immediates:
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}
  - U: {instr[31:12],12'b0}
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}
  - All sign-extended from instr[31].
- Illegal when any of:
  - instr[1:0]!=2'b11
  - opcode not in the class list
  - OP with funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101
  - OP_IMM shift (funct3 001/101) with instr[31:25] not 0000000 (or 0100000 for 101)
  - JALR funct3!=0
  - BRANCH funct3 010/011
  - LOAD funct3 011/110/111
  - STORE funct3 >=011
- Illegal beats are buffered and delivered like any other; out_rd=0, out_imm=0.
- out_* fields are held stable while out_valid & ~out_ready.
- Reset mid-operation discards everything immediately, regardless of handshake state.

Test Plan:
- Reset then single beat: in_instr=0x00500093 (addi x1,x0,5), pc=0x0 -> next cycle out_valid=1, op_class=7, rd=1, rs1=0, imm=0x00000005, illegal=0; pop -> out_count=1.
- Immediate formats: 0xFE000EE3 (beq x0,x0,-4) -> class 4, imm=0xFFFFFFFC, rd=0; 0x123450B7 (lui x1) -> class 0, imm=0x12345000; 0xFF9FF06F (jal x0,-8) -> class 2, imm=0xFFFFFFF8.
- Backpressure: out_ready=0, push 3 beats -> in_ready=0 after 2nd push, 3rd beat held at fetch; release out_ready -> 3 beats out in order, out_count=3.
- Flush with occupancy 2 plus incoming beat -> next cycle out_valid=0, in_ready=1, neither held nor incoming beat ever appears.
- Illegal: 0x00000000, 0x4000F033 (funct7 0100000 with funct3 111), 0x00001067 (JALR funct3=1) -> each out_illegal=1, op_class=15, rd=0.
- Async reset asserted mid-stream with out_valid=1 -> out_valid, in_ready, out_count all 0 without a clock edge.
